multi_switch_edge_toggle: RTL and testbench
===========================================

// Module: multi_switch_edge_toggle
// PURPOSE
//  N-channel switch front end: per-channel 2-flop synchroniser, debounce filter, edge detector
//  and toggle/pulse output. Next generation of the single-switch debounced toggle on the 25 MHz board.
//  Adds channel count, edge-mode select, pulse output and a wrap-around event counter.
//  Sits between raw board switches and user logic (LED drivers, menu FSMs).
// PARAMETERS
//  NUM_CH          4        number of independent switch channels (1..8)
//  DEBOUNCE_LIMIT  250000   stable cycles required to accept a new level (10 ms @ 25 MHz), >=2
//  EDGE_MODE       0        0 = falling (release), 1 = rising (press), 2 = both edges
//  CNT_W           8        width of each per-channel event counter
// PORTS
//  i_Clk      in   1             system clock, 25 MHz
//  i_Rst_L    in   1             asynchronous active-low reset
//  i_Switch   in   NUM_CH        raw, asynchronous switch levels
//  i_Clear    in   NUM_CH        sync per-channel clear of toggle state and counter
//  o_Level    out  NUM_CH        debounced switch level
//  o_Toggle   out  NUM_CH        flips on each selected edge
//  o_Pulse    out  NUM_CH        1-cycle strobe on each selected edge
//  o_Count    out  NUM_CH*CNT_W  per-channel edge count, channel k at [k*CNT_W +: CNT_W]
//  o_Any      out  1             OR of o_Pulse
// BEHAVIOUR
//  - Reset (i_Rst_L=0, async assert, sync-release via i_Clk only): sync flops, o_Level, previous
//    level, o_Toggle, o_Pulse, o_Count, o_Any, debounce counters all 0. No edge is reported on
//    the first debounced transition to 1 unless it is a selected edge (rising) -- it IS reported.
//  - Synchroniser: two flops per channel; s2 is the filtered input.
//  - Debounce per channel: counter width $clog2(DEBOUNCE_LIMIT).
//    s2 == o_Level -> counter <= 0. s2 != o_Level -> counter+1; when counter == DEBOUNCE_LIMIT-1,
//    o_Level <= s2 and counter <= 0. Any glitch back to o_Level before limit restarts from 0.
//  - Edge: rise = o_Level & ~prev, fall = ~o_Level & prev; prev <= o_Level every cycle.
//    sel = fall / rise / rise|fall per EDGE_MODE. o_Pulse <= sel (registered).
//  - Latency: i_Switch change held stable at cycle 0 -> o_Level changes at cycle DEBOUNCE_LIMIT+2,
//    o_Pulse high for exactly cycle DEBOUNCE_LIMIT+3. o_Toggle and o_Count update same edge as o_Pulse.
//  - Counter: o_Count += 1 per pulse, wraps 2^CNT_W-1 -> 0, no saturation, no flag.
//  - i_Clear[k] and pulse in same cycle: clear wins (toggle 0, count 0, pulse still emitted).
//  - Channels fully independent; simultaneous edges on all channels all counted.
//  - o_Any registered with o_Pulse (same cycle), not a cycle later.
//  - Reset mid-debounce discards partial count; no pulse generated by reset itself.
// STRUCTURE
//  - Shared package sw_pkg: EDGE_FALL=0, EDGE_RISE=1, EDGE_BOTH=2 constants; DEBOUNCE_10MS_25MHZ=250000.
//  - Sub-module switch_debounce_ch (sync + debounce + edge detect, one channel), outputs level and
//    sel-edge; top instantiates NUM_CH copies in a generate loop and owns toggle/counter/o_Any.
//  - Elaboration check: EDGE_MODE>2 or DEBOUNCE_LIMIT<2 -> $error.
// TESTING (sim with DEBOUNCE_LIMIT=4, NUM_CH=4, CNT_W=3)
//  1 EDGE_MODE=1, i_Switch[0] 0->1 held -> o_Level[0]=1 at cycle 6, o_Pulse[0]/o_Any=1 only at
//    cycle 7, o_Toggle[0]=1, o_Count[0]=1; other channels unchanged.
//  2 Bounce: i_Switch[1] 1 for 3 cycles, 0 for 1, then 1 held -> no pulse until 6 cycles after
//    final rise; exactly one pulse total.
//  3 EDGE_MODE=2, 9 full press/release cycles on ch2 -> 18 pulses, o_Count[2] wraps 7->0, ends at 2,
//    o_Toggle[2]=0.
//  4 EDGE_MODE=0, all 4 channels pressed and released same cycle -> single pulses on release
//    only, all 4 simultaneous, o_Any one cycle, each count=1.
//  5 i_Clear[3] asserted in pulse cycle -> o_Pulse[3]=1, o_Toggle[3]=0, o_Count[3]=0 next cycle.
//  6 i_Rst_L low for 1 cycle mid-debounce (counter=2) -> all outputs 0 immediately (async);
//    held input requires full 6 cycles after release to register.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared constants for the multi-channel switch front end
package sw_pkg;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_BOTH = 2;

  localparam int DEBOUNCE_10MS_25MHZ = 250000;

endpackage

// File: rtl/switch_debounce_ch.sv
// rtl/switch_debounce_ch.sv - one channel: 2-flop synchroniser, debounce filter, selected-edge detect
module switch_debounce_ch
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS_25MHZ,
  parameter int EDGE_MODE      = EDGE_FALL
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Edge
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          sync_1;
  logic          sync_2;
  logic          prev_level;
  logic [CW-1:0] stable_cnt;
  logic          rise;
  logic          fall;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      o_Level    <= 1'b0;
      prev_level <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_1     <= i_Switch;
      sync_2     <= sync_1;
      prev_level <= o_Level;
      // Any sample that agrees with the accepted level restarts the stability window.
      if (sync_2 == o_Level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        o_Level    <= sync_2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign rise = o_Level & ~prev_level;
  assign fall = ~o_Level & prev_level;

  always_comb begin
    o_Edge = 1'b0;
    case (EDGE_MODE)
      EDGE_FALL: o_Edge = fall;
      EDGE_RISE: o_Edge = rise;
      EDGE_BOTH: o_Edge = rise | fall;
      default:   o_Edge = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_switch_edge_toggle.sv
// rtl/multi_switch_edge_toggle.sv - N-channel debounced switch front end with toggle, pulse and event count
module multi_switch_edge_toggle
  import sw_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS_25MHZ,
  parameter int EDGE_MODE      = EDGE_FALL,
  parameter int CNT_W          = 8
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic [NUM_CH-1:0]         i_Switch,
  input  logic [NUM_CH-1:0]         i_Clear,
  output logic [NUM_CH-1:0]         o_Level,
  output logic [NUM_CH-1:0]         o_Toggle,
  output logic [NUM_CH-1:0]         o_Pulse,
  output logic [NUM_CH*CNT_W-1:0]   o_Count,
  output logic                      o_Any
);

  if (EDGE_MODE > EDGE_BOTH || DEBOUNCE_LIMIT < 2 || NUM_CH < 1 || NUM_CH > 8) begin : g_bad_param
    $error("multi_switch_edge_toggle: illegal EDGE_MODE, DEBOUNCE_LIMIT or NUM_CH");
  end

  logic [NUM_CH-1:0] sel_edge;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    switch_debounce_ch #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .EDGE_MODE      (EDGE_MODE)
    ) u_ch (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Switch (i_Switch[k]),
      .o_Level  (o_Level[k]),
      .o_Edge   (sel_edge[k])
    );
  end

  // Pulse, toggle, count and o_Any all update on the same edge; clear beats a coincident edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Pulse  <= '0;
      o_Toggle <= '0;
      o_Count  <= '0;
      o_Any    <= 1'b0;
    end else begin
      o_Pulse <= sel_edge;
      o_Any   <= |sel_edge;
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_Clear[k]) begin
          o_Toggle[k]                <= 1'b0;
          o_Count[k*CNT_W +: CNT_W]  <= '0;
        end else if (sel_edge[k]) begin
          o_Toggle[k]                <= ~o_Toggle[k];
          o_Count[k*CNT_W +: CNT_W]  <= o_Count[k*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_switch_edge_toggle.sv
// tb/tb_multi_switch_edge_toggle.sv - scoreboard bench for multi_switch_edge_toggle in all three edge modes
module tb_multi_switch_edge_toggle;

  localparam int NCH = 4;
  localparam int DL  = 4;
  localparam int CW  = 3;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] tog;
    logic [11:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sw    [3];
  logic [3:0]  clr   [3];
  logic [3:0]  lvl   [3];
  logic [3:0]  tog   [3];
  logic [3:0]  pls   [3];
  logic [11:0] cnt   [3];
  logic        any_o [3];

  exp_t        q [3][$];
  logic [3:0]  m_tog [3];
  logic [2:0]  m_cnt [3][4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  exp_t mon_e;

  multi_switch_edge_toggle #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DL), .EDGE_MODE(0), .CNT_W(CW)) u_dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw[0]), .i_Clear(clr[0]), .o_Level(lvl[0]),
    .o_Toggle(tog[0]), .o_Pulse(pls[0]), .o_Count(cnt[0]), .o_Any(any_o[0]));

  multi_switch_edge_toggle #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DL), .EDGE_MODE(1), .CNT_W(CW)) u_dut1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw[1]), .i_Clear(clr[1]), .o_Level(lvl[1]),
    .o_Toggle(tog[1]), .o_Pulse(pls[1]), .o_Count(cnt[1]), .o_Any(any_o[1]));

  multi_switch_edge_toggle #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DL), .EDGE_MODE(2), .CNT_W(CW)) u_dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw[2]), .i_Clear(clr[2]), .o_Level(lvl[2]),
    .o_Toggle(tog[2]), .o_Pulse(pls[2]), .o_Count(cnt[2]), .o_Any(any_o[2]));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest expected event of that DUT.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (any_o[d] !== |pls[d]) begin
        n_fail++;
        $display("FAIL any_or dut%0d cyc %0d: o_Any=%b required %b", d, cyc, any_o[d], |pls[d]);
      end
      while (q[d].size() > 0 && q[d][0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_pulse dut%0d: expected at cyc %0d mask %b, o_Pulse stayed 0000", d, q[d][0].cyc, q[d][0].mask);
        void'(q[d].pop_front());
      end
      if (pls[d] !== 4'b0) begin
        n_checks++;
        if (q[d].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse dut%0d cyc %0d: o_Pulse=%b required 0000", d, cyc, pls[d]);
        end else begin
          mon_e = q[d].pop_front();
          if (mon_e.cyc != cyc || pls[d] !== mon_e.mask || tog[d] !== mon_e.tog || cnt[d] !== mon_e.cnt) begin
            n_fail++;
            $display("FAIL pulse_event dut%0d: cyc %0d pulse %b tog %b cnt %h, required cyc %0d pulse %b tog %b cnt %h",
                     d, cyc, pls[d], tog[d], cnt[d], mon_e.cyc, mon_e.mask, mon_e.tog, mon_e.cnt);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input int at, input logic [3:0] mask, input logic [3:0] clear);
    exp_t e;
    for (int ch = 0; ch < 4; ch++) begin
      if (clear[ch]) begin
        m_tog[d][ch] = 1'b0;
        m_cnt[d][ch] = 3'd0;
      end else if (mask[ch]) begin
        m_tog[d][ch] = ~m_tog[d][ch];
        m_cnt[d][ch] = m_cnt[d][ch] + 3'd1;
      end
    end
    e.cyc  = at;
    e.mask = mask;
    e.tog  = m_tog[d];
    for (int ch = 0; ch < 4; ch++) e.cnt[ch*3 +: 3] = m_cnt[d][ch];
    q[d].push_back(e);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      m_tog[d] = 4'b0;
      for (int ch = 0; ch < 4; ch++) m_cnt[d][ch] = 3'd0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      sw[d]  = 4'b0;
      clr[d] = 4'b0;
    end
    model_clear();
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (lvl[d] !== 4'b0 || tog[d] !== 4'b0 || pls[d] !== 4'b0 || cnt[d] !== 12'h0 || any_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: lvl %b tog %b pls %b cnt %h any %b, required all 0",
                 d, lvl[d], tog[d], pls[d], cnt[d], any_o[d]);
      end
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_rise_latency();
    int c;
    sw[1][0] = 1'b1;
    c = cyc;
    push_exp(1, c + 7, 4'b0001, 4'b0);
    repeat (5) tick();
    n_checks++;
    if (lvl[1] !== 4'b0000) begin
      n_fail++;
      $display("FAIL level_before_limit: o_Level=%b required 0000", lvl[1]);
    end
    tick();
    n_checks++;
    if (lvl[1] !== 4'b0001) begin
      n_fail++;
      $display("FAIL level_at_cycle6: o_Level=%b required 0001", lvl[1]);
    end
    for (int i = 0; i < 40 && q[1].size() != 0; i++) tick();
    n_checks++;
    if (q[1].size() != 0) begin
      n_fail++;
      $display("FAIL rise_wait: %0d events outstanding, required 0", q[1].size());
    end
  endtask

  task automatic test_bounce();
    int c;
    sw[1][1] = 1'b1;
    repeat (3) tick();
    sw[1][1] = 1'b0;
    tick();
    sw[1][1] = 1'b1;
    c = cyc;
    push_exp(1, c + 7, 4'b0010, 4'b0);
    for (int i = 0; i < 40 && q[1].size() != 0; i++) tick();
    n_checks++;
    if (q[1].size() != 0) begin
      n_fail++;
      $display("FAIL bounce_wait: %0d events outstanding, required 0", q[1].size());
    end
    repeat (10) tick();
  endtask

  task automatic test_both_wrap();
    for (int n = 0; n < 9; n++) begin
      sw[2][2] = 1'b1;
      push_exp(2, cyc + 7, 4'b0100, 4'b0);
      repeat (8) tick();
      sw[2][2] = 1'b0;
      push_exp(2, cyc + 7, 4'b0100, 4'b0);
      repeat (8) tick();
    end
    for (int i = 0; i < 40 && q[2].size() != 0; i++) tick();
    n_checks++;
    if (q[2].size() != 0) begin
      n_fail++;
      $display("FAIL wrap_wait: %0d events outstanding, required 0", q[2].size());
    end
    n_checks++;
    if (cnt[2][8:6] !== 3'd2 || tog[2][2] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_final: count2=%0d toggle2=%b, required 2 and 0", cnt[2][8:6], tog[2][2]);
    end
  endtask

  task automatic test_simultaneous_release();
    sw[0] = 4'b1111;
    repeat (8) tick();
    sw[0] = 4'b0000;
    push_exp(0, cyc + 7, 4'b1111, 4'b0);
    for (int i = 0; i < 40 && q[0].size() != 0; i++) tick();
    n_checks++;
    if (q[0].size() != 0) begin
      n_fail++;
      $display("FAIL release_wait: %0d events outstanding, required 0", q[0].size());
    end
    repeat (4) tick();
    n_checks++;
    if (cnt[0] !== {3'd1, 3'd1, 3'd1, 3'd1} || tog[0] !== 4'b1111) begin
      n_fail++;
      $display("FAIL release_counts: cnt=%h tog=%b, required 249 1111", cnt[0], tog[0]);
    end
  endtask

  task automatic test_clear_wins();
    sw[1][3] = 1'b1;
    push_exp(1, cyc + 7, 4'b1000, 4'b0);
    repeat (10) tick();
    sw[1][3] = 1'b0;
    repeat (8) tick();
    sw[1][3] = 1'b1;
    push_exp(1, cyc + 7, 4'b1000, 4'b1000);
    repeat (6) tick();
    clr[1] = 4'b1000;
    tick();
    clr[1] = 4'b0000;
    for (int i = 0; i < 40 && q[1].size() != 0; i++) tick();
    n_checks++;
    if (q[1].size() != 0) begin
      n_fail++;
      $display("FAIL clear_wait: %0d events outstanding, required 0", q[1].size());
    end
    n_checks++;
    if (tog[1][3] !== 1'b0 || cnt[1][11:9] !== 3'd0) begin
      n_fail++;
      $display("FAIL clear_state: toggle3=%b count3=%0d, required 0 and 0", tog[1][3], cnt[1][11:9]);
    end
  endtask

  task automatic test_reset_mid_debounce();
    sw[1][2] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (lvl[d] !== 4'b0 || tog[d] !== 4'b0 || pls[d] !== 4'b0 || cnt[d] !== 12'h0 || any_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: lvl %b tog %b pls %b cnt %h any %b, required all 0",
                 d, lvl[d], tog[d], pls[d], cnt[d], any_o[d]);
      end
    end
    model_clear();
    tick();
    rst_n = 1'b1;
    push_exp(1, cyc + 7, 4'b1111, 4'b0);
    repeat (5) tick();
    n_checks++;
    if (lvl[1] !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_early: o_Level=%b required 0000", lvl[1]);
    end
    tick();
    n_checks++;
    if (lvl[1] !== 4'b1111) begin
      n_fail++;
      $display("FAIL post_reset_level: o_Level=%b required 1111", lvl[1]);
    end
    for (int i = 0; i < 40 && q[1].size() != 0; i++) tick();
    n_checks++;
    if (q[1].size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_wait: %0d events outstanding, required 0", q[1].size());
    end
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_bounce();
    test_both_wrap();
    test_simultaneous_release();
    test_clear_wins();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
